// File: rtl/ahblite_slave_mux_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type for the slave mux.
package ahb_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR1 = 3'd1,
    ERR2 = 3'd2,
    TO1  = 3'd3,
    TO2  = 3'd4
  } ds_state_e;

endpackage

// File: rtl/ahblite_slave_mux_if.sv
// AHB-Lite bus bundle between the address decoder/slaves and the data-phase mux.
interface ahblite_slave_mux_if #(
  parameter int NSLV = 8
);
  import ahb_pkg::*;

  logic [NSLV-1:0]        HSEL_A;
  logic [1:0]             HTRANS;
  logic [NSLV*DATA_W-1:0] HRDATA_S;
  logic [NSLV-1:0]        HREADYOUT_S;
  logic [NSLV-1:0]        HRESP_S;
  logic [DATA_W-1:0]      HRDATA;
  logic                   HREADY;
  logic                   HRESP;
  logic                   TIMEOUT_IRQ;

  modport master (
    output HSEL_A, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HRDATA, HREADY, HRESP, TIMEOUT_IRQ
  );

  modport slave (
    input  HSEL_A, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HRDATA, HREADY, HRESP, TIMEOUT_IRQ
  );

endinterface

// File: rtl/ahblite_slave_mux_default_slave.sv
// Default slave: two-cycle ERROR for unmapped active transfers, plus an optional
// wait-state watchdog enabled by AHB_MUX_TIMEOUT_EN.
module ahblite_default_slave
  import ahb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic unmapped_req,
`ifdef AHB_MUX_TIMEOUT_EN
  input  logic hready,
  input  logic slv_wait,
`endif
  output logic ds_active,
  output logic ds_hready,
  output logic ds_hresp,
  output logic timeout_irq
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  ds_state_e state_q, state_d;

`ifdef AHB_MUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_hit;

  // The hit fires on the last permitted wait cycle, so the count that would
  // follow it is TIMEOUT_CYCLES-1 when TO1 starts.
  assign timeout_hit = (state_q == IDLE) && slv_wait &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (hready || (state_q != IDLE)) begin
      cnt_q <= '0;
    end else if (slv_wait) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ERR2 and TO2 both complete with HREADY=1, so a new unmapped transfer
  // accepted there chains straight into ERR1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (unmapped_req) begin
          state_d = ERR1;
        end
`ifdef AHB_MUX_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = TO1;
        end
`endif
      end
      ERR1:      state_d = ERR2;
      TO1:       state_d = TO2;
      ERR2, TO2: state_d = unmapped_req ? ERR1 : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    ds_active   = 1'b1;
    ds_hready   = 1'b1;
    ds_hresp    = HRESP_ERROR;
    timeout_irq = 1'b0;
    case (state_q)
      IDLE: begin
        ds_active = 1'b0;
        ds_hresp  = HRESP_OKAY;
      end
      ERR1, TO1: ds_hready = 1'b0;
      ERR2:      ds_hready = 1'b1;
      TO2: begin
`ifdef AHB_MUX_TIMEOUT_EN
        timeout_irq = 1'b1;
`endif
      end
      default: begin
        ds_active = 1'b0;
        ds_hresp  = HRESP_OKAY;
      end
    endcase
  end

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite data-phase mux: latches the decoder select, steers the chosen slave's
// response to the master, and falls back to the default slave (AHB_MUX_TIMEOUT_EN adds a watchdog).
module ahblite_slave_mux
  import ahb_pkg::*;
#(
  parameter int NSLV           = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahblite_slave_mux_if.slave  bus
);

  logic [NSLV-1:0]   sel_q;
  logic [NSLV-1:0]   sel_next;
  logic              htrans_active;
  logic              unmapped_req;
  logic              hready;
  logic              slv_hready;
  logic              slv_hresp;
  logic [DATA_W-1:0] slv_hrdata;
  logic              ds_active;
  logic              ds_hready;
  logic              ds_hresp;
  logic              timeout_irq;

  // Descending scan so the lowest set bit is the one left standing.
  always_comb begin
    sel_next = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (bus.HSEL_A[i]) begin
        sel_next    = '0;
        sel_next[i] = 1'b1;
      end
    end
  end

  assign htrans_active = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);
  assign unmapped_req  = hready && (sel_next == '0) && htrans_active;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sel_q <= '0;
    end else if (hready) begin
      sel_q <= sel_next;
    end
  end

  always_comb begin
    slv_hready = 1'b1;
    slv_hresp  = HRESP_OKAY;
    slv_hrdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) begin
        slv_hready = bus.HREADYOUT_S[i];
        slv_hresp  = bus.HRESP_S[i];
        slv_hrdata = bus.HRDATA_S[DATA_W*i +: DATA_W];
      end
    end
  end

`ifdef AHB_MUX_TIMEOUT_EN
  logic slv_wait;
  assign slv_wait = (|sel_q) && !slv_hready;
`endif

  ahblite_default_slave #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_default_slave (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .unmapped_req (unmapped_req),
`ifdef AHB_MUX_TIMEOUT_EN
    .hready       (hready),
    .slv_wait     (slv_wait),
`endif
    .ds_active    (ds_active),
    .ds_hready    (ds_hready),
    .ds_hresp     (ds_hresp),
    .timeout_irq  (timeout_irq)
  );

  // Whenever the default slave or watchdog owns the bus, the slave is ignored.
  assign hready          = ds_active ? ds_hready : slv_hready;
  assign bus.HREADY      = hready;
  assign bus.HRESP       = ds_active ? ds_hresp : slv_hresp;
  assign bus.HRDATA      = ds_active ? '0 : slv_hrdata;
  assign bus.TIMEOUT_IRQ = timeout_irq;

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Directed bench for ahblite_slave_mux with a per-cycle expected-response scoreboard.
module tb_ahblite_slave_mux;
  import ahb_pkg::*;

  localparam int NSLV   = 8;
  localparam int TO_CYC = 4;

  typedef struct {
    string       tag;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic        irq;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESETn;
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  ahblite_slave_mux_if #(.NSLV(NSLV)) bus ();

  ahblite_slave_mux #(
    .NSLV           (NSLV),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [31:0] v);
    bus.HRDATA_S[32*i +: 32] = v;
  endtask

  // Push expectation for the current cycle, compare at the falling edge, then
  // move to just after the next rising edge where the caller drives inputs.
  task automatic step(input string tag, input logic hr, input logic rs,
                      input logic [31:0] d, input logic irq);
    exp_t e;
    e.tag = tag; e.hready = hr; e.hresp = rs; e.hrdata = d; e.irq = irq;
    sb.push_back(e);
    @(negedge HCLK);
    e = sb.pop_front();
    check1({e.tag, ".hready"}, {31'b0, bus.HREADY},      {31'b0, e.hready});
    check1({e.tag, ".hresp"},  {31'b0, bus.HRESP},       {31'b0, e.hresp});
    check1({e.tag, ".hrdata"}, bus.HRDATA,               e.hrdata);
    check1({e.tag, ".irq"},    {31'b0, bus.TIMEOUT_IRQ}, {31'b0, e.irq});
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn         = 1'b0;
    bus.HSEL_A      = '0;
    bus.HTRANS      = HTRANS_IDLE;
    bus.HRDATA_S    = '0;
    bus.HREADYOUT_S = '1;
    bus.HRESP_S     = '0;
    for (int i = 0; i < NSLV; i++) set_slot(i, 32'hC0DE_0000 + i);

    @(posedge HCLK);
    #1;
    step("reset", 1'b1, 1'b0, 32'h0, 1'b0);
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) step("idle", 1'b1, 1'b0, 32'h0, 1'b0);

    // Read from slave 1 with two wait states
    bus.HSEL_A = 8'h02; bus.HTRANS = HTRANS_NONSEQ;
    step("rd1_addr", 1'b1, 1'b0, 32'h0, 1'b0);
    bus.HSEL_A = 8'h00; bus.HTRANS = HTRANS_IDLE;
    bus.HREADYOUT_S[1] = 1'b0; set_slot(1, 32'hDEADBEEF);
    step("rd1_wait0", 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    step("rd1_wait1", 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    bus.HREADYOUT_S[1] = 1'b1;
    step("rd1_done", 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    step("rd1_after", 1'b1, 1'b0, 32'h0, 1'b0);

    // Single unmapped active transfer
    bus.HTRANS = HTRANS_NONSEQ;
    step("unm_addr", 1'b1, 1'b0, 32'h0, 1'b0);
    bus.HTRANS = HTRANS_IDLE;
    step("unm_err1", 1'b0, 1'b1, 32'h0, 1'b0);
    step("unm_err2", 1'b1, 1'b1, 32'h0, 1'b0);
    step("unm_after", 1'b1, 1'b0, 32'h0, 1'b0);

    // Back-to-back unmapped transfers
    bus.HTRANS = HTRANS_NONSEQ;
    step("b2b_addr", 1'b1, 1'b0, 32'h0, 1'b0);
    step("b2b_err1a", 1'b0, 1'b1, 32'h0, 1'b0);
    step("b2b_err2a", 1'b1, 1'b1, 32'h0, 1'b0);
    bus.HTRANS = HTRANS_IDLE;
    step("b2b_err1b", 1'b0, 1'b1, 32'h0, 1'b0);
    step("b2b_err2b", 1'b1, 1'b1, 32'h0, 1'b0);
    step("b2b_after", 1'b1, 1'b0, 32'h0, 1'b0);

    // Unmapped BUSY gets a zero-wait OKAY
    bus.HTRANS = HTRANS_BUSY;
    step("busy_addr", 1'b1, 1'b0, 32'h0, 1'b0);
    bus.HTRANS = HTRANS_IDLE;
    step("busy_data", 1'b1, 1'b0, 32'h0, 1'b0);

    // Priority: slaves 2 and 4 both selected, slave 2 wins
    bus.HSEL_A = 8'h14; bus.HTRANS = HTRANS_NONSEQ;
    set_slot(2, 32'h2222_2222); set_slot(4, 32'h4444_4444);
    bus.HREADYOUT_S[4] = 1'b0; bus.HRESP_S[4] = 1'b1;
    step("prio_addr", 1'b1, 1'b0, 32'h0, 1'b0);
    bus.HSEL_A = 8'h00; bus.HTRANS = HTRANS_IDLE;
    step("prio_data", 1'b1, 1'b0, 32'h2222_2222, 1'b0);
    bus.HREADYOUT_S[4] = 1'b1; bus.HRESP_S[4] = 1'b0;
    step("prio_after", 1'b1, 1'b0, 32'h0, 1'b0);

    // HSEL_A changes while stalled must not disturb the latched select
    bus.HSEL_A = 8'h02; bus.HTRANS = HTRANS_NONSEQ;
    step("stall_addr", 1'b1, 1'b0, 32'h0, 1'b0);
    bus.HREADYOUT_S[1] = 1'b0; bus.HSEL_A = 8'h08; set_slot(3, 32'h3333_3333);
    step("stall_w0", 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    step("stall_w1", 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    bus.HREADYOUT_S[1] = 1'b1;
    step("stall_done", 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    bus.HSEL_A = 8'h00; bus.HTRANS = HTRANS_IDLE;
    step("stall_s3", 1'b1, 1'b0, 32'h3333_3333, 1'b0);
    step("stall_after", 1'b1, 1'b0, 32'h0, 1'b0);

    // Slave 0 hangs forever
    bus.HSEL_A = 8'h01; bus.HTRANS = HTRANS_NONSEQ; set_slot(0, 32'h0000_AAAA);
    step("hang_addr", 1'b1, 1'b0, 32'h0, 1'b0);
    bus.HSEL_A = 8'h00; bus.HTRANS = HTRANS_IDLE; bus.HREADYOUT_S[0] = 1'b0;
`ifdef AHB_MUX_TIMEOUT_EN
    for (int i = 0; i < TO_CYC - 1; i++) step("wd_wait", 1'b0, 1'b0, 32'h0000_AAAA, 1'b0);
    step("wd_to1", 1'b0, 1'b1, 32'h0, 1'b0);
    step("wd_to2", 1'b1, 1'b1, 32'h0, 1'b1);
    step("wd_after", 1'b1, 1'b0, 32'h0, 1'b0);
    bus.HSEL_A = 8'h01; bus.HTRANS = HTRANS_NONSEQ;
    step("rstmid_addr", 1'b1, 1'b0, 32'h0, 1'b0);
    bus.HSEL_A = 8'h00; bus.HTRANS = HTRANS_IDLE;
    step("rstmid_wait", 1'b0, 1'b0, 32'h0000_AAAA, 1'b0);
`else
    for (int i = 0; i < 10; i++) step("hang_wait", 1'b0, 1'b0, 32'h0000_AAAA, 1'b0);
`endif

    // Reset during a stalled data phase recovers without an ERROR
    HRESETn = 1'b0;
    step("rstmid_hold", 1'b0, 1'b0, 32'h0000_AAAA, 1'b0);
    HRESETn = 1'b1; bus.HREADYOUT_S[0] = 1'b1;
    step("rstmid_rel0", 1'b1, 1'b0, 32'h0, 1'b0);
    step("rstmid_rel1", 1'b1, 1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
